// File: rtl/fpu_arbiter.sv
// Two-requester round-robin front end for a single shared, fixed-latency FPU.
// Holds the granted operands stable for the FPU and captures its result after FPU_LATENCY cycles.
module fpu_arbiter #(
    parameter int FPU_LATENCY = 30,
    parameter int N_CNT_W     = 8
) (
    input  logic        clock_100k,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,

    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_status,

    output logic [31:0] fpu_op_a,
    output logic [31:0] fpu_op_b,
    input  logic [31:0] fpu_data,
    input  logic [3:0]  fpu_status,

    output logic        busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    localparam logic [N_CNT_W-1:0] CNT_LOAD = N_CNT_W'(FPU_LATENCY - 1);
    localparam logic [N_CNT_W-1:0] CNT_ONE  = N_CNT_W'(1);

    logic [0:0]         state;
    logic [N_CNT_W-1:0] cnt;
    logic               last_grant;
    logic               pending_id;
    logic               grant_sel;
    logic               accept;

    // On a tie the requester that was not served last wins; reset leaves last_grant at 1 so req0 wins first.
    always_comb begin
        grant_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant;
        end else if (req1_valid) begin
            grant_sel = 1'b1;
        end
    end

    always_comb begin
        accept     = (state == IDLE) && (req0_valid || req1_valid);
        req0_ready = accept && req0_valid && !grant_sel;
        req1_ready = accept && req1_valid && grant_sel;
        busy       = (state == WAIT);
    end

    always_ff @(posedge clock_100k or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            fpu_op_a   <= '0;
            fpu_op_b   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_status <= '0;
            pending_id <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        fpu_op_a   <= grant_sel ? req1_a : req0_a;
                        fpu_op_b   <= grant_sel ? req1_b : req0_b;
                        pending_id <= grant_sel;
                        last_grant <= grant_sel;
                        cnt        <= CNT_LOAD;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    // Operands stay untouched here so the FPU sees them stable for the whole latency.
                    if (cnt == '0) begin
                        rsp_data   <= fpu_data;
                        rsp_status <= fpu_status;
                        rsp_id     <= pending_id;
                        rsp_valid  <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL have parameter FPU_LATENCY, default 30: cycles the shared FPU needs between stable operands and a valid result; legal range 1..255.
REQ-002 SHALL have parameter N_CNT_W, default 8: width of the latency counter.
REQ-003 SHALL have port clock_100k  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req0_valid  input  1  requester 0 has an operation pending.
REQ-006 SHALL have port req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-007 SHALL have port req0_a  input  32  requester 0 operand A (sign 1, exponent 11, mantissa 20).
REQ-008 SHALL have port req0_b  input  32  requester 0 operand B.
REQ-009 SHALL have port req1_valid  input  1  requester 1 has an operation pending.
REQ-010 SHALL have port req1_ready  output  1  requester 1 operands accepted this cycle.
REQ-011 SHALL have port req1_a  input  32  requester 1 operand A.
REQ-012 SHALL have port req1_b  input  32  requester 1 operand B.
REQ-013 SHALL have port rsp_valid  output  1  one-cycle pulse, result on rsp_data/rsp_status.
REQ-014 SHALL have port rsp_id  output  1  requester the result belongs to.
REQ-015 SHALL have port rsp_data  output  32  captured FPU data_out.
REQ-016 SHALL have port rsp_status  output  4  captured FPU status_out.
REQ-017 SHALL have port fpu_op_a  output  32  drives FPU op_a.
REQ-018 SHALL have port fpu_op_b  output  32  drives FPU op_b.
REQ-019 SHALL have port fpu_data  input  32  from FPU data_out.
REQ-020 SHALL have port fpu_status  input  4  from FPU status_out.
REQ-021 SHALL have port busy  output  1  high while an operation is in flight (WAIT state).

Function
REQ-022 SHALL implement two states: IDLE and WAIT.
REQ-023 In IDLE, SHALL grant at most one requester; reqN_ready is combinational, high only for the granted requester with reqN_valid high.
REQ-024 Arbitration SHALL be round-robin: if both valid, grant the requester not granted last; if one valid, grant it.
REQ-025 On accept (valid & ready), SHALL register operands into fpu_op_a/fpu_op_b, record the grant as rsp_id-to-be and last-grant pointer, load counter with FPU_LATENCY-1, enter WAIT.
REQ-026 fpu_op_a/fpu_op_b SHALL remain stable throughout WAIT and hold their last value in IDLE; changes on reqN_a/b after accept have no effect.
REQ-027 In WAIT, both readys SHALL be 0; counter decrements each cycle.
REQ-028 When counter is 0 in WAIT, SHALL register fpu_data/fpu_status into rsp_data/rsp_status, set rsp_id, pulse rsp_valid for exactly one cycle, return to IDLE.
REQ-029 Latency: accept at edge T -> fpu_op valid from T, rsp_valid high in the cycle following edge T+FPU_LATENCY.
REQ-030 A new accept SHALL be allowed in the same cycle rsp_valid is high; peak throughput one op per FPU_LATENCY+1 cycles.
REQ-031 rsp_data/rsp_status/rsp_id SHALL hold their value until the next response.

Reset
REQ-032 On reset high, immediately: state IDLE, counter 0, fpu_op_a/b 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_status 0, busy 0, last-grant pointer = 1 (requester 0 wins first tie).
REQ-033 Reset during WAIT SHALL abort the operation with no rsp_valid pulse.

Verification
REQ-034 Reset, req0 3FF00000+3FF00000 -> req0_ready same cycle, busy next cycle, one rsp_valid FPU_LATENCY+1 cycles after accept, rsp_id 0, rsp_data 40000000.
REQ-035 After reset, req0 40000000+BFF00000 and req1 C0080000+C0000000 valid together -> req0 first (rsp_data 3FF00000, id 0), then req1 (rsp_data C0140000, id 1); readys never both high.
REQ-036 Both requesters held valid for 4 operations -> grants alternate 0,1,0,1; each rsp_id matches its grant.
REQ-037 Reset pulsed at counter midpoint -> no rsp_valid, busy 0, fpu_op_a/b 0; a following req1 40040000+40040000 completes with rsp_data 40140000.
REQ-038 req1 changes req1_a during its WAIT -> fpu_op_a unchanged, result matches the accepted operands.
